// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small transmit FIFO, runtime parity and 1/2 stop bits.
// Bit timing is paced by the external s_tick strobe (OS_TICK strobes per bit).
//
// state  | meaning
// IDLE   | line high, pop the FIFO head when one is available
// START  | start bit (low) for OS_TICK ticks
// DATA   | DBIT data bits, LSB first
// PARITY | optional parity bit
// STOP   | line high for OS_TICK or 2*OS_TICK ticks
module uart_tx_fifo #(
  parameter int DBIT    = 8,
  parameter int OS_TICK = 16,
  parameter int ADDR_W  = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            wr_en,
  input  logic [DBIT-1:0] din,
  input  logic [1:0]      parity_mode,
  input  logic            stop2,
  output logic            full,
  output logic            empty,
  output logic            overrun,
  output logic            tx_busy,
  output logic            tx_done_tick,
  output logic            dout
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int SW    = $clog2(2 * OS_TICK);
  localparam int NW    = $clog2(DBIT);
  localparam logic [SW-1:0] S_ONE  = SW'(OS_TICK - 1);
  localparam logic [SW-1:0] S_TWO  = SW'(2 * OS_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [DBIT-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count;
  logic              push, pop;

  state_t          state_q, state_d;
  logic [SW-1:0]   s_q, s_d, s_end;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            par_q, par_d;
  logic            par_en_q, par_en_d;
  logic            stop2_q, stop2_d;
  logic            dout_d;

  assign full  = (count == (ADDR_W+1)'(DEPTH));
  assign empty = (count == '0);
  assign push  = wr_en & ~full;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= wr_en & full;
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      s_q      <= '0;
      n_q      <= '0;
      b_q      <= '0;
      par_q    <= 1'b0;
      par_en_q <= 1'b0;
      stop2_q  <= 1'b0;
      dout     <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      n_q      <= n_d;
      b_q      <= b_d;
      par_q    <= par_d;
      par_en_q <= par_en_d;
      stop2_q  <= stop2_d;
      dout     <= dout_d;
      tx_busy  <= (state_d != IDLE);
    end
  end

  assign s_end = stop2_q ? S_TWO : S_ONE;

  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    n_d          = n_q;
    b_d          = b_q;
    par_d        = par_q;
    par_en_d     = par_en_q;
    stop2_d      = stop2_q;
    pop          = 1'b0;
    tx_done_tick = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          b_d      = mem[rd_ptr];
          // parity of the whole word is fixed at load; odd simply inverts it
          par_d    = (^mem[rd_ptr]) ^ (parity_mode == 2'b10);
          par_en_d = (parity_mode == 2'b01) || (parity_mode == 2'b10);
          stop2_d  = stop2;
          s_d      = '0;
          n_d      = '0;
          state_d  = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == S_ONE) begin
            s_d     = '0;
            state_d = DATA;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == S_ONE) begin
            s_d = '0;
            b_d = b_q >> 1;
            if (n_q == N_LAST) state_d = par_en_q ? PARITY : STOP;
            else               n_d     = n_q + NW'(1);
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (s_q == S_ONE) begin
            s_d     = '0;
            state_d = STOP;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_q == s_end) begin
            s_d          = '0;
            tx_done_tick = 1'b1;
            state_d      = IDLE;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // line level is registered alongside the state it belongs to
    case (state_d)
      START:   dout_d = 1'b0;
      DATA:    dout_d = b_d[0];
      PARITY:  dout_d = par_d;
      default: dout_d = 1'b1;
    endcase
  end

endmodule
